// File: rtl/mips_if_pkg.sv
// ---------------------------------------------------------------------------
// mips_if_pkg
// Shared definitions for the instruction-fetch stage of the pipelined MIPS
// core: reset PC, NOP encoding, the fetch FSM state type and the
// {pc, instr} entry held by the fetch instruction buffer.
// ---------------------------------------------------------------------------
package mips_if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,  // may issue a request to instruction memory
        WAIT  = 2'd1,  // one request granted, its response is wanted
        DRAIN = 2'd2   // one request granted, its response must be dropped
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ibuf_entry_t;

    // Sequential fetch address; 32-bit arithmetic wraps 0xFFFF_FFFC to 0.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_ibuf.sv
// ---------------------------------------------------------------------------
// if_ibuf
// Two-entry synchronous FIFO of {pc, instr} between instruction memory and
// the IF/ID register. Slot 0 is always the head; a pop shifts slot 1 down.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset (clears the count)
//   push        write push_data at the tail (ignored when full)
//   push_data   entry to write
//   pop         drop the head (ignored when empty)
//   flush       empty the FIFO; wins over push and pop in the same cycle
//   count       number of valid entries, 0..2
//   head        oldest entry; only meaningful when count != 0
// ---------------------------------------------------------------------------
module if_ibuf
    import mips_if_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  ibuf_entry_t push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  count,
    output ibuf_entry_t head
);

    ibuf_entry_t slot0_q, slot0_d;
    ibuf_entry_t slot1_q, slot1_d;
    logic [1:0]  count_q, count_d;
    logic        do_push;
    logic        do_pop;

    always_comb begin
        do_push = push && (count_q != 2'd2);
        do_pop  = pop  && (count_q != 2'd0);
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                // Simultaneous push/pop is only possible with one entry held,
                // so the new entry becomes the head directly.
                2'b11: slot0_d = push_data;
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_d = push_data;
                    end else begin
                        slot1_d = push_data;
                    end
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Only the occupancy is reset; slot contents are qualified by count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign count = count_q;
    assign head  = slot0_q;

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Owns the fetch PC, issues one request at a time
// over a req/gnt/rvalid handshake, buffers responses in a 2-entry queue and
// presents the queue head to the IF/ID register. Handles branch redirects
// and load-use stalls from ID; responses in flight across a redirect are
// discarded.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   br_flag/br_target  redirect from ID (target word-aligned)
//   load_stop_request  ID stall, head is held
//   imem_req/addr      fetch request and address
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  in-order response, at least one cycle after gnt
//   if_PC/if_instr     presented PC and instruction (NOP when empty)
//   if_valid           queue non-empty
// ---------------------------------------------------------------------------
module if_fetch
    import mips_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    input  logic        load_stop_request,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_PC,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    // A redirect that lands on a raised but ungranted request freezes that
    // request: hold_q keeps it alive at hold_addr_q while fetch_pc_q already
    // carries the new target.
    logic         hold_q, hold_d;
    logic [31:0]  hold_addr_q, hold_addr_d;
    // Low for the first cycle out of reset so no request is raised while
    // rstn is still asserted.
    logic         started_q;

    logic         req_fire;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    ibuf_entry_t  head;
    ibuf_entry_t  push_data;

    if_ibuf u_ibuf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (br_flag),
        .count     (count),
        .head      (head)
    );

    assign push_data = '{pc: req_pc_q, instr: imem_rdata};

    // Request is a function of registered state only, so it cannot glitch
    // with br_flag or load_stop_request once raised.
    always_comb begin
        imem_req = 1'b0;
        if (started_q && (state_q == REQ)) begin
            imem_req = hold_q || (count != 2'd2);
        end
    end

    assign imem_addr = hold_q ? hold_addr_q : fetch_pc_q;
    assign req_fire  = imem_req && imem_gnt;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        hold_d      = hold_q;
        hold_addr_d = hold_addr_q;
        push        = 1'b0;

        case (state_q)
            REQ: begin
                if (req_fire) begin
                    if (hold_q) begin
                        hold_d  = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = pc_next(fetch_pc_q);
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // Redirect overrides the normal flow; the queue is flushed by the
        // buffer itself and any response arriving now is dropped.
        if (br_flag) begin
            push       = 1'b0;
            fetch_pc_d = br_target;
            case (state_q)
                WAIT, DRAIN: state_d = imem_rvalid ? REQ : DRAIN;
                default: begin
                    if (req_fire) begin
                        hold_d  = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        state_d = REQ;
                        if (imem_req) begin
                            hold_d      = 1'b1;
                            hold_addr_d = imem_addr;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            hold_q      <= 1'b0;
            hold_addr_q <= RESET_PC;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            hold_q      <= hold_d;
            hold_addr_q <= hold_addr_d;
            started_q   <= 1'b1;
        end
    end

    assign if_valid = (count != 2'd0);
    assign pop      = if_valid && !load_stop_request && !br_flag;
    assign if_PC    = if_valid ? head.pc : fetch_pc_q;
    assign if_instr = if_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed and randomized bench for if_fetch. A behavioural instruction
// memory answers requests with configurable or random grant/response delay.
// The reference model is the program-order stream: after reset or a
// redirect, consumed instructions must be consecutive words from the start
// address, each carrying the memory word at its PC.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        br_flag;
    logic [31:0] br_target;
    logic        load_stop_request;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_PC;
    logic [31:0] if_instr;
    logic        if_valid;

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .br_flag           (br_flag),
        .br_target         (br_target),
        .load_stop_request (load_stop_request),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .if_PC             (if_PC),
        .if_instr          (if_instr),
        .if_valid          (if_valid)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // memory model state
    int          gnt_wait = 0;
    int          rsp_wait = 1;
    bit          gnt_rand = 0;
    bit          rsp_rand = 0;
    int          m_gnt_cnt = 0;
    int          m_rsp_cnt = 0;
    bit          m_pend = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] gnt_log[$];

    // reference stream state
    logic [31:0] exp_pc = RPC;
    logic [31:0] consumed[$];
    bit          prev_hold = 0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) + {a[15:0], 16'h0013};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int next_gnt_wait();
        return gnt_rand ? int'($urandom_range(0, 3)) : gnt_wait;
    endfunction

    // One clock: called just after a falling edge, returns after the next.
    task automatic cycle(input logic ls, input logic br, input logic [31:0] tgt);
        logic        g;
        logic        rv;
        logic [31:0] rd;
        g  = 1'b0;
        rv = 1'b0;
        rd = '0;

        chk1("one_outstanding", imem_req && m_pend, 1'b0);
        if (prev_hold) begin
            chk1("req_held", imem_req, 1'b1);
            chk("addr_held", imem_addr, prev_addr);
        end

        if (m_pend) begin
            if (m_rsp_cnt == 0) begin
                rv     = 1'b1;
                rd     = memf(m_addr);
                m_pend = 0;
            end else begin
                m_rsp_cnt--;
            end
        end
        if (imem_req) begin
            if (m_gnt_cnt == 0) begin
                g         = 1'b1;
                m_pend    = 1;
                m_addr    = imem_addr;
                m_rsp_cnt = rsp_rand ? int'($urandom_range(0, 3)) : rsp_wait - 1;
                gnt_log.push_back(imem_addr);
                m_gnt_cnt = next_gnt_wait();
            end else begin
                m_gnt_cnt--;
            end
        end
        prev_hold = imem_req && !g;
        prev_addr = imem_addr;

        if (!if_valid) chk("nop_when_empty", if_instr, 32'h0);
        if (if_valid && !ls && !br) begin
            chk("pop_pc", if_PC, exp_pc);
            chk("pop_instr", if_instr, memf(exp_pc));
            consumed.push_back(if_PC);
            exp_pc = exp_pc + 32'd4;
        end
        if (br) exp_pc = tgt;

        imem_gnt          = g;
        imem_rvalid       = rv;
        imem_rdata        = rd;
        load_stop_request = ls;
        br_flag           = br;
        br_target         = tgt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn              = 1'b0;
        imem_gnt          = 1'b0;
        imem_rvalid       = 1'b0;
        imem_rdata        = '0;
        load_stop_request = 1'b0;
        br_flag           = 1'b0;
        br_target         = '0;
        m_pend            = 0;
        prev_hold         = 0;
        repeat (2) @(negedge clk);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_PC", if_PC, RPC);
        rstn      = 1'b1;
        exp_pc    = RPC;
        m_gnt_cnt = next_gnt_wait();
        consumed.delete();
        gnt_log.delete();
    endtask

    initial begin
        bit found;
        int idx;
        int pops_before;
        logic        ls;
        logic        br;
        logic [31:0] tgt;

        // ---- reset and first fetch
        gnt_wait = 0; rsp_wait = 1;
        do_reset();
        chk1("req_low_before_edge", imem_req, 1'b0);
        cycle(0, 0, 0);
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, RPC);
        cycle(0, 0, 0);
        chk1("no_valid_before_rsp", if_valid, 1'b0);
        chk("no_instr_before_rsp", if_instr, 32'h0);
        cycle(0, 0, 0);
        chk1("first_valid", if_valid, 1'b1);
        chk("first_pc", if_PC, RPC);
        repeat (10) cycle(0, 0, 0);
        chk("seq0", (consumed.size() > 0) ? consumed[0] : 32'hX, 32'h3000);
        chk("seq1", (consumed.size() > 1) ? consumed[1] : 32'hX, 32'h3004);
        chk("seq2", (consumed.size() > 2) ? consumed[2] : 32'hX, 32'h3008);

        // ---- stall fill
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0);
            if (if_valid) chk("stall_head", if_PC, RPC);
        end
        chk1("full_no_req", imem_req, 1'b0);
        chk1("full_valid", if_valid, 1'b1);
        chk("full_two_grants", gnt_log.size(), 2);
        repeat (20) cycle(0, 0, 0);
        chk("resume_cnt_ok", (consumed.size() >= 4) ? 32'd1 : 32'd0, 32'd1);

        // ---- redirect with response in flight
        rsp_wait = 2;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, 0, 0);
            if (gnt_log.size() > 0 && gnt_log[$] == 32'h3008) found = 1;
        end
        chk1("saw_gnt_3008", found, 1'b1);
        cycle(0, 1, 32'h4000);
        for (int i = 0; i < 20 && !imem_req; i++) cycle(0, 0, 0);
        chk1("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, 32'h4000);
        for (int i = 0; i < 20 && !if_valid; i++) cycle(0, 0, 0);
        chk1("redir_valid", if_valid, 1'b1);
        chk("redir_pc", if_PC, 32'h4000);
        repeat (6) cycle(0, 0, 0);

        // ---- redirect while request pending without grant
        gnt_wait = 3; rsp_wait = 1;
        do_reset();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 32'h3004) begin
                found = 1;
                break;
            end
            cycle(0, 0, 0);
        end
        chk1("saw_req_3004", found, 1'b1);
        idx = gnt_log.size();
        cycle(0, 1, 32'h5000);
        chk1("pend_req_kept", imem_req, 1'b1);
        chk("pend_addr_kept", imem_addr, 32'h3004);
        for (int i = 0; i < 30 && gnt_log.size() < idx + 2; i++) cycle(0, 0, 0);
        chk("pend_gnt_orig", (gnt_log.size() > idx) ? gnt_log[idx] : 32'hX, 32'h3004);
        chk("pend_gnt_new", (gnt_log.size() > idx + 1) ? gnt_log[idx + 1] : 32'hX, 32'h5000);
        for (int i = 0; i < 20 && !if_valid; i++) cycle(0, 0, 0);
        chk("pend_first_pc", if_PC, 32'h5000);
        repeat (6) cycle(0, 0, 0);

        // ---- br + stall with full queue
        gnt_wait = 0; rsp_wait = 1;
        do_reset();
        repeat (12) cycle(1, 0, 0);
        chk1("bs_full_no_req", imem_req, 1'b0);
        cycle(1, 1, 32'h6000);
        chk1("bs_flushed", if_valid, 1'b0);
        chk("bs_pc", if_PC, 32'h6000);
        chk1("bs_req", imem_req, 1'b1);
        chk("bs_addr", imem_addr, 32'h6000);
        repeat (10) cycle(0, 0, 0);

        // ---- wrap
        for (int i = 0; i < 20 && !imem_req; i++) cycle(0, 0, 0);
        cycle(0, 1, 32'hFFFF_FFFC);
        idx = gnt_log.size();
        for (int i = 0; i < 40 && gnt_log.size() < idx + 2; i++) cycle(0, 0, 0);
        chk("wrap_first", (gnt_log.size() > idx) ? gnt_log[idx] : 32'hX, 32'hFFFF_FFFC);
        chk("wrap_next", (gnt_log.size() > idx + 1) ? gnt_log[idx + 1] : 32'hX, 32'h0000_0000);

        // ---- async reset mid-WAIT
        rsp_wait = 3;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 0);
            if (if_valid && m_pend) begin
                found = 1;
                break;
            end
        end
        chk1("saw_mid_wait", found, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk1("async_imem_req", imem_req, 1'b0);
        chk1("async_if_valid", if_valid, 1'b0);
        chk("async_if_instr", if_instr, 32'h0);
        chk("async_if_PC", if_PC, RPC);
        rsp_wait = 1;
        do_reset();
        cycle(0, 0, 0);
        chk("restart_addr", imem_addr, RPC);
        repeat (8) cycle(0, 0, 0);

        // ---- randomized traffic
        gnt_rand = 1; rsp_rand = 1;
        do_reset();
        pops_before = consumed.size();
        for (int i = 0; i < 2000; i++) begin
            ls  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 24) == 0);
            tgt = $urandom() & 32'hFFFF_FFFC;
            cycle(ls, br, tgt);
        end
        chk("random_progress", (consumed.size() - pops_before >= 50) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipelined MIPS core. It owns the fetch PC, issues one request at a time to the instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions in a 2-entry queue. The queue head drives the IF/ID pipeline register. Branch redirects and load-use stalls from ID are handled here, and any response already in flight across a redirect is discarded.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- br_flag  in  1  redirect from ID; fetch restarts at br_target.
- br_target  in  32  redirect address, word-aligned.
- load_stop_request  in  1  ID stall; the queue head is not consumed.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; valid while imem_req=1.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; in order, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_PC  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction; 0 (NOP) when if_valid=0.
- if_valid  out  1  queue non-empty.

## Operation
- Registers:
  - fetch_pc: next address to request.
  - req_pc: address of the outstanding request.
  - FSM state.
  - Queue of {pc, instr}: 2 entries, count 0..2.
- FSM states:
  - REQ:
    - imem_req = (count < 2); imem_addr = fetch_pc.
    - On req&gnt: req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), go to WAIT.
  - WAIT: imem_req=0. On rvalid, push {req_pc, rdata} and go to REQ.
  - DRAIN: imem_req=0. On rvalid, discard the data and go to REQ.
- Request rule: once imem_req rises, imem_req and imem_addr stay stable until gnt, even if br_flag or load_stop_request arrives.
- Overflow guard: at most one request is outstanding, and requests are issued only when count < 2. A response therefore always finds room.
- Output: if_PC/if_instr/if_valid come from the queue head. When the queue is empty, if_PC = fetch_pc and if_instr = 0.
- pop = if_valid & ~load_stop_request & ~br_flag. Push and pop may occur in the same cycle, and count stays unchanged.
- Redirect (br_flag=1) takes priority over everything else:
  - Flush the queue (count <= 0) and set fetch_pc <= br_target.
  - Next state is DRAIN if state==WAIT and no rvalid arrives this cycle.
  - Next state is DRAIN if state==REQ and req&gnt occurs this cycle.
  - Otherwise next state is REQ.
  - A response arriving in the redirect cycle is discarded.
- br_flag and load_stop_request together: treated as a redirect.
- br_flag while a request is pending but not yet granted:
  - The pending request completes at its original address, and its response is dropped via DRAIN.
  - The new target is requested after that, never in the same request.

## Timing
- Reset values:
  - state=REQ, fetch_pc=RESET_PC, count=0, req_pc=RESET_PC.
  - Outputs: imem_req=0, if_valid=0, if_instr=0, if_PC=RESET_PC.
- Reset is asynchronous: outputs reach their reset values immediately when rstn falls, including mid-WAIT.
- An outstanding response after reset release is not tracked. The memory side is reset together with this block.
- imem_req first asserts in the first cycle after rstn deasserts.
- Latency:
  - gnt in cycle N and rvalid in cycle N+1: if_valid in cycle N+2.
  - Peak throughput is 1 instruction per 2 cycles (single outstanding request).
- After a redirect in cycle N, with no drain and zero-wait memory: imem_addr=br_target in cycle N+1.

## Structure
- Shared package mips_if_pkg:
  - RESET_PC_DEFAULT (32'h3000).
  - NOP_INSTR (32'h0).
  - FSM state enum {REQ, WAIT, DRAIN}.
- Sub-module if_ibuf: 2-entry synchronous FIFO of {pc, instr}.
  - Ports: push, pop, flush, count, head, with async active-low reset.
  - Flush has priority over push and pop in the same cycle.
- Top if_fetch holds the FSM, the fetch_pc/req_pc registers and the output muxing.

## Test plan
- Reset and first fetch: rstn low then released; memory grants immediately and returns the next cycle.
  - if_PC/if_instr sequence 0x3000, 0x3004, 0x3008 with correct data.
  - if_valid=0 and if_instr=0 before the first response.
- Stall fill: hold load_stop_request=1 for 10 cycles.
  - Exactly 2 entries are buffered and imem_req=0 once count=2.
  - Head stays 0x3000 throughout.
  - Release resumes the stream in order with no loss or duplication.
- Redirect with response in flight: br_flag=1, br_target=0x4000 in the cycle after a gnt for 0x3008.
  - The 0x3008 response is dropped and the queue is flushed.
  - Next imem_addr=0x4000 and the next if_PC=0x4000.
- Redirect while request pending without gnt (gnt delayed 3 cycles):
  - imem_addr stays 0x3004 until gnt, and that response is discarded.
  - Then 0x5000 is requested.
- Simultaneous br_flag and load_stop_request with queue full: flush wins, count=0, fetch restarts at br_target.
- Wrap and async reset:
  - Redirect to 0xFFFF_FFFC: the following fetch address is 0x0000_0000.
  - Assert rstn low mid-WAIT with rvalid pending: outputs go to reset values immediately, and fetch restarts at 0x3000.
